ov_fifo_reader: RTL and testbench

OV_FIFO_READER -- requirements
Module: ov_fifo_reader

---
 rtl/ov_fifo_pkg.sv | 26 ++
 rtl/ov_rclk_gen.sv | 57 +++++
 rtl/ov_fifo_reader.sv | 190 +++++++++++++++++++
 tb/tb_ov_fifo_reader.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ov_fifo_pkg.sv
// Shared types and default constants for the OV camera FIFO reader.
// Holds the reader FSM state enum and a counter-width helper.
package ov_fifo_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RRST,
        S_RD_LO,
        S_RD_HI,
        S_WAIT_FULL,
        S_WRITE,
        S_DONE
    } state_e;

    localparam int unsigned H_PIX_DEF    = 320;
    localparam int unsigned V_LINES_DEF  = 240;
    localparam int unsigned BPP_DEF      = 2;
    localparam int unsigned CLK_DIV_DEF  = 1;
    localparam int unsigned RRST_CYC_DEF = 3;

    // Width of a counter spanning 0..n-1, never below one bit.
    function automatic int cw(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ov_rclk_gen.sv
// OV_RCLK phase generator: CLK_DIV-cycle low/high phases while running,
// parked high otherwise, with phase-end and sample strobes.
module ov_rclk_gen
    import ov_fifo_pkg::*;
#(
    parameter int unsigned CLK_DIV = CLK_DIV_DEF
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic run_i,
    output logic rclk_o,
    output logic end_o,
    output logic sample_o
);

    localparam int CW = cw(CLK_DIV);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          phase_q, phase_d;
    logic          run_q;
    logic          rclk_q, rclk_d;

    assign end_o    = run_q && (cnt_q == CW'(CLK_DIV - 1));
    assign sample_o = end_o && phase_q;
    assign rclk_o   = rclk_q;

    // run_i is the next-state view, so rclk_q lines up with the FSM state.
    always_comb begin
        cnt_d   = '0;
        phase_d = 1'b0;
        if (run_i && run_q) begin
            if (end_o) begin
                cnt_d   = '0;
                phase_d = ~phase_q;
            end else begin
                cnt_d   = cnt_q + 1'b1;
                phase_d = phase_q;
            end
        end
        rclk_d = run_i ? phase_d : 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
            run_q   <= 1'b0;
            rclk_q  <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            run_q   <= run_i;
            rclk_q  <= rclk_d;
        end
    end

endmodule

// File: rtl/ov_fifo_reader.sv
// Reads one frame from an OV camera FIFO, packs bytes into pixel words
// and writes them to a TX cache with SOF/EOL framing and backpressure.
module ov_fifo_reader
    import ov_fifo_pkg::*;
#(
    parameter int unsigned H_PIX    = H_PIX_DEF,
    parameter int unsigned V_LINES  = V_LINES_DEF,
    parameter int unsigned BPP      = BPP_DEF,
    parameter int unsigned CLK_DIV  = CLK_DIV_DEF,
    parameter int unsigned RRST_CYC = RRST_CYC_DEF
) (
    input  logic             CLK_40M,
    input  logic             RST,
    input  logic             READ_EN,
    input  logic [7:0]       OV_DATA,
    input  logic             TX_CACHE_WRFULL,
    output logic             RD_FRAME,
    output logic             OV_RRST,
    output logic             OV_RCLK,
    output logic [8*BPP-1:0] TX_CACHE_DATA,
    output logic             TX_CACHE_WRREQ,
    output logic             TX_CACHE_SOF,
    output logic             TX_CACHE_EOL,
    output logic             FRAME_DONE
);

    localparam int XW = cw(H_PIX);
    localparam int YW = cw(V_LINES);
    localparam int RW = cw(RRST_CYC);
    localparam int BW = cw(BPP);
    localparam int DW = 8 * BPP;

    state_e          state_q, state_d;
    logic [RW-1:0]   rcnt_q, rcnt_d;
    logic [BW-1:0]   bcnt_q, bcnt_d;
    logic [XW-1:0]   x_q, x_d;
    logic [YW-1:0]   y_q, y_d;
    logic [DW-1:0]   pack_q, pack_d;
    logic [DW-1:0]   data_q, data_d;
    logic            wrreq_q, wrreq_d;
    logic            sof_q, sof_d;
    logic            eol_q, eol_d;
    logic            done_q, done_d;
    logic            rdf_q, rdf_d;
    logic            rrst_q, rrst_d;
    logic            run_d;
    logic            ph_end, ph_smp;
    logic            eol_now;

    ov_rclk_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_rclk (
        .clk_i   (CLK_40M),
        .rst_i   (RST),
        .run_i   (run_d),
        .rclk_o  (OV_RCLK),
        .end_o   (ph_end),
        .sample_o(ph_smp)
    );

    assign eol_now = (x_q == XW'(H_PIX - 1));

    always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        bcnt_d  = bcnt_q;
        x_d     = x_q;
        y_d     = y_q;
        pack_d  = pack_q;
        data_d  = data_q;
        wrreq_d = 1'b0;
        sof_d   = 1'b0;
        eol_d   = 1'b0;
        done_d  = 1'b0;
        rdf_d   = rdf_q;
        unique case (state_q)
            S_IDLE: begin
                rdf_d = 1'b1;
                if (READ_EN) begin
                    state_d = S_RRST;
                    rdf_d   = 1'b0;
                    rcnt_d  = '0;
                    bcnt_d  = '0;
                end
            end
            S_RRST: begin
                if (ph_smp) begin
                    if (rcnt_q == RW'(RRST_CYC - 1)) begin
                        rcnt_d  = '0;
                        state_d = S_RD_LO;
                    end else begin
                        rcnt_d = rcnt_q + 1'b1;
                    end
                end
            end
            S_RD_LO: begin
                if (ph_end) state_d = S_RD_HI;
            end
            S_RD_HI: begin
                if (ph_smp) begin
                    pack_d      = pack_q << 8;
                    pack_d[7:0] = OV_DATA;
                    if (bcnt_q == BW'(BPP - 1)) begin
                        bcnt_d  = '0;
                        state_d = TX_CACHE_WRFULL ? S_WAIT_FULL
                                                  : S_WRITE;
                    end else begin
                        bcnt_d  = bcnt_q + 1'b1;
                        state_d = S_RD_LO;
                    end
                end
            end
            S_WAIT_FULL: begin
                if (!TX_CACHE_WRFULL) state_d = S_WRITE;
            end
            S_WRITE: begin
                wrreq_d = 1'b1;
                data_d  = pack_q;
                sof_d   = (x_q == '0) && (y_q == '0);
                eol_d   = eol_now;
                state_d = S_RD_LO;
                if (eol_now) begin
                    x_d = '0;
                    if (y_q == YW'(V_LINES - 1)) begin
                        y_d     = '0;
                        state_d = S_DONE;
                    end else begin
                        y_d = y_q + 1'b1;
                    end
                end else begin
                    x_d = x_q + 1'b1;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                rdf_d   = 1'b1;
                x_d     = '0;
                y_d     = '0;
                rcnt_d  = '0;
                bcnt_d  = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        run_d  = (state_d == S_RRST) || (state_d == S_RD_LO) ||
                 (state_d == S_RD_HI);
        rrst_d = (state_d != S_RRST);
    end

    always_ff @(posedge CLK_40M) begin
        if (RST) begin
            state_q <= S_IDLE;
            rcnt_q  <= '0;
            bcnt_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
            pack_q  <= '0;
            data_q  <= '0;
            wrreq_q <= 1'b0;
            sof_q   <= 1'b0;
            eol_q   <= 1'b0;
            done_q  <= 1'b0;
            rdf_q   <= 1'b1;
            rrst_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            rcnt_q  <= rcnt_d;
            bcnt_q  <= bcnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            pack_q  <= pack_d;
            data_q  <= data_d;
            wrreq_q <= wrreq_d;
            sof_q   <= sof_d;
            eol_q   <= eol_d;
            done_q  <= done_d;
            rdf_q   <= rdf_d;
            rrst_q  <= rrst_d;
        end
    end

    assign RD_FRAME       = rdf_q;
    assign OV_RRST        = rrst_q;
    assign TX_CACHE_DATA  = data_q;
    assign TX_CACHE_WRREQ = wrreq_q;
    assign TX_CACHE_SOF   = sof_q;
    assign TX_CACHE_EOL   = eol_q;
    assign FRAME_DONE     = done_q;

endmodule

// File: tb/tb_ov_fifo_reader.sv
// Directed bench for ov_fifo_reader: two configurations, each fed by a
// behavioural camera FIFO, checked against hand-computed word tables.
module tb_ov_fifo_reader;

    typedef struct {
        logic [15:0] data;
        logic        sof;
        logic        eol;
        int          dcyc;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        ren_a = 1'b0, ren_b = 1'b0;
    logic        full_a = 1'b0, full_b = 1'b0;
    logic [7:0]  dat_a = 8'h0, dat_b = 8'h0;
    logic        rdf_a, rrst_a, rclk_a, wr_a, sof_a, eol_a, fd_a;
    logic        rdf_b, rrst_b, rclk_b, wr_b, sof_b, eol_b, fd_b;
    logic [15:0] txd_a;
    logic [7:0]  txd_b;

    ov_fifo_reader #(
        .H_PIX(4), .V_LINES(2), .BPP(2), .CLK_DIV(1), .RRST_CYC(3)
    ) dut_a (
        .CLK_40M(clk), .RST(rst), .READ_EN(ren_a), .OV_DATA(dat_a),
        .TX_CACHE_WRFULL(full_a), .RD_FRAME(rdf_a), .OV_RRST(rrst_a),
        .OV_RCLK(rclk_a), .TX_CACHE_DATA(txd_a), .TX_CACHE_WRREQ(wr_a),
        .TX_CACHE_SOF(sof_a), .TX_CACHE_EOL(eol_a), .FRAME_DONE(fd_a)
    );

    ov_fifo_reader #(
        .H_PIX(4), .V_LINES(2), .BPP(1), .CLK_DIV(3), .RRST_CYC(3)
    ) dut_b (
        .CLK_40M(clk), .RST(rst), .READ_EN(ren_b), .OV_DATA(dat_b),
        .TX_CACHE_WRFULL(full_b), .RD_FRAME(rdf_b), .OV_RRST(rrst_b),
        .OV_RCLK(rclk_b), .TX_CACHE_DATA(txd_b), .TX_CACHE_WRREQ(wr_b),
        .TX_CACHE_SOF(sof_b), .TX_CACHE_EOL(eol_b), .FRAME_DONE(fd_b)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Camera FIFO: byte n holds value n; a rising RCLK with RRST low
    // rewinds to byte 0.
    int   ptr_a = 0, ptr_b = 0;
    logic pa = 1'b1, pb = 1'b1;
    always @(posedge clk) begin
        #1;
        if (rclk_a && !pa) begin
            if (!rrst_a) begin
                ptr_a = 0;
                dat_a = 8'h00;
            end else begin
                dat_a = 8'(ptr_a);
                ptr_a++;
            end
        end
        pa = rclk_a;
        if (rclk_b && !pb) begin
            if (!rrst_b) begin
                ptr_b = 0;
                dat_b = 8'h00;
            end else begin
                dat_b = 8'(ptr_b);
                ptr_b++;
            end
        end
        pb = rclk_b;
    end

    logic [15:0] wd_a[$];
    logic        ws_a[$], we_a[$];
    int          wc_a[$];
    logic [7:0]  wd_b[$];
    logic        ws_b[$], we_b[$];
    int          wc_b[$];
    int          lo_b[$];
    int fd_cnt_a = 0, fd_cyc_a = 0, rr_a = 0;
    int fd_cnt_b = 0, fd_cyc_b = 0, rr_b = 0, lo_len = 0;
    logic ma = 1'b1, mb = 1'b1;

    always @(negedge clk) begin
        if (wr_a) begin
            wd_a.push_back(txd_a);
            ws_a.push_back(sof_a);
            we_a.push_back(eol_a);
            wc_a.push_back(cyc);
        end
        if (fd_a) begin
            fd_cnt_a++;
            fd_cyc_a = cyc;
        end
        if (rclk_a && !ma && !rrst_a) rr_a++;
        ma = rclk_a;
        if (wr_b) begin
            wd_b.push_back(txd_b);
            ws_b.push_back(sof_b);
            we_b.push_back(eol_b);
            wc_b.push_back(cyc);
        end
        if (fd_b) begin
            fd_cnt_b++;
            fd_cyc_b = cyc;
        end
        if (rclk_b && !mb && !rrst_b) rr_b++;
        if (!rclk_b) lo_len++;
        else if (lo_len != 0) begin
            lo_b.push_back(lo_len);
            lo_len = 0;
        end
        mb = rclk_b;
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic clear_a();
        wd_a.delete(); ws_a.delete(); we_a.delete(); wc_a.delete();
        rr_a = 0;
    endtask

    task automatic reset_vals_a(input string tag);
        chk({tag, " rd_frame"}, int'(rdf_a), 1);
        chk({tag, " rrst"}, int'(rrst_a), 1);
        chk({tag, " rclk"}, int'(rclk_a), 1);
        chk({tag, " data"}, int'(txd_a), 0);
        chk({tag, " wrreq"}, int'(wr_a), 0);
        chk({tag, " sof"}, int'(sof_a), 0);
        chk({tag, " eol"}, int'(eol_a), 0);
        chk({tag, " frame_done"}, int'(fd_a), 0);
    endtask

    task automatic start_a(output int base, input bit hold);
        @(negedge clk);
        ren_a = 1'b1;
        base = cyc + 1;
        if (!hold) begin
            @(negedge clk);
            ren_a = 1'b0;
        end
    endtask

    task automatic wait_fd_a(input int n, input int budget);
        int k = 0;
        while (fd_cnt_a < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("a frame_done timeout", int'(fd_cnt_a >= n), 1);
    endtask

    task automatic wait_words_a(input int n, input int budget);
        int k = 0;
        while (wd_a.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("a word timeout", int'(wd_a.size() >= n), 1);
    endtask

    task automatic check_a(input int base, input int off, input int i,
                           input bit do_cyc, input vec_t v);
        if (wd_a.size() <= off + i) begin
            chk($sformatf("a word%0d missing", off + i), 0, 1);
        end else begin
            chk($sformatf("a data%0d", off + i), int'(wd_a[off+i]),
                int'(v.data));
            chk($sformatf("a sof%0d", off + i), int'(ws_a[off+i]),
                int'(v.sof));
            chk($sformatf("a eol%0d", off + i), int'(we_a[off+i]),
                int'(v.eol));
            if (do_cyc)
                chk($sformatf("a cyc%0d", off + i), wc_a[off+i] - base,
                    v.dcyc);
        end
    endtask

    vec_t va[8];
    vec_t vb[8];

    initial begin
        int base;
        int fdn;
        bit ok;

        va[0] = '{16'h0001, 1'b1, 1'b0, 11};
        va[1] = '{16'h0203, 1'b0, 1'b0, 16};
        va[2] = '{16'h0405, 1'b0, 1'b0, 21};
        va[3] = '{16'h0607, 1'b0, 1'b1, 26};
        va[4] = '{16'h0809, 1'b0, 1'b0, 31};
        va[5] = '{16'h0A0B, 1'b0, 1'b0, 36};
        va[6] = '{16'h0C0D, 1'b0, 1'b0, 41};
        va[7] = '{16'h0E0F, 1'b0, 1'b1, 46};
        vb[0] = '{16'h0000, 1'b1, 1'b0, 25};
        vb[1] = '{16'h0001, 1'b0, 1'b0, 32};
        vb[2] = '{16'h0002, 1'b0, 1'b0, 39};
        vb[3] = '{16'h0003, 1'b0, 1'b1, 46};
        vb[4] = '{16'h0004, 1'b0, 1'b0, 53};
        vb[5] = '{16'h0005, 1'b0, 1'b0, 60};
        vb[6] = '{16'h0006, 1'b0, 1'b0, 67};
        vb[7] = '{16'h0007, 1'b0, 1'b1, 74};

        repeat (3) @(negedge clk);
        reset_vals_a("rst");
        chk("rst b rd_frame", int'(rdf_b), 1);
        chk("rst b rclk", int'(rclk_b), 1);
        chk("rst b wrreq", int'(wr_b), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single frame, READ_EN pulsed for one cycle only.
        clear_a();
        fdn = fd_cnt_a + 1;
        start_a(base, 1'b0);
        repeat (4) @(negedge clk);
        chk("a rd_frame busy", int'(rdf_a), 0);
        wait_fd_a(fdn, 200);
        chk("a word count", wd_a.size(), 8);
        for (int i = 0; i < 8; i++) check_a(base, 0, i, 1'b1, va[i]);
        chk("a frame_done cyc", fd_cyc_a - base, 47);
        chk("a rrst pulses", rr_a, 3);
        chk("a rd_frame idle", int'(rdf_a), 1);
        @(negedge clk);
        chk("a frame_done pulse", int'(fd_a), 0);

        // Backpressure while word 2 is assembled.
        clear_a();
        fdn = fd_cnt_a + 1;
        start_a(base, 1'b0);
        wait_words_a(2, 100);
        full_a = 1'b1;
        ok = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (k >= 6 && (rclk_a !== 1'b1 || wr_a !== 1'b0)) ok = 1'b0;
        end
        chk("a stall rclk/wrreq", int'(ok), 1);
        chk("a stall words", wd_a.size(), 2);
        full_a = 1'b0;
        wait_fd_a(fdn, 200);
        chk("a stall word count", wd_a.size(), 8);
        for (int i = 0; i < 8; i++) check_a(base, 0, i, 1'b0, va[i]);

        // Reset pulse while word 5 is being read.
        clear_a();
        start_a(base, 1'b0);
        wait_words_a(5, 100);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        reset_vals_a("midrst");
        rst = 1'b0;
        clear_a();
        fdn = fd_cnt_a + 1;
        start_a(base, 1'b0);
        wait_fd_a(fdn, 200);
        chk("a post-rst count", wd_a.size(), 8);
        for (int i = 0; i < 8; i++) check_a(base, 0, i, 1'b1, va[i]);
        chk("a post-rst rrst pulses", rr_a, 3);

        // READ_EN held high: two back-to-back frames.
        clear_a();
        fdn = fd_cnt_a + 1;
        start_a(base, 1'b1);
        wait_fd_a(fdn, 200);
        repeat (2) @(negedge clk);
        ren_a = 1'b0;
        wait_fd_a(fdn + 1, 200);
        chk("a b2b fd2 cyc", fd_cyc_a - base, 48 + 47);
        for (int i = 0; i < 8; i++) check_a(base, 0, i, 1'b1, va[i]);
        for (int i = 0; i < 8; i++)
            check_a(base + 48, 8, i, 1'b1, va[i]);
        chk("a b2b rrst pulses", rr_a, 6);
        repeat (20) @(negedge clk);
        chk("a b2b total words", wd_a.size(), 16);
        chk("a b2b rd_frame", int'(rdf_a), 1);

        // CLK_DIV=3, BPP=1 configuration.
        wd_b.delete(); ws_b.delete(); we_b.delete(); wc_b.delete();
        lo_b.delete();
        rr_b = 0;
        fdn = fd_cnt_b + 1;
        @(negedge clk);
        ren_b = 1'b1;
        base = cyc + 1;
        @(negedge clk);
        ren_b = 1'b0;
        for (int k = 0; k < 300 && fd_cnt_b < fdn; k++) @(negedge clk);
        chk("b frame_done timeout", int'(fd_cnt_b >= fdn), 1);
        chk("b word count", wd_b.size(), 8);
        for (int i = 0; i < 8 && i < wd_b.size(); i++) begin
            chk($sformatf("b data%0d", i), int'(wd_b[i]),
                int'(vb[i].data));
            chk($sformatf("b sof%0d", i), int'(ws_b[i]), int'(vb[i].sof));
            chk($sformatf("b eol%0d", i), int'(we_b[i]), int'(vb[i].eol));
            chk($sformatf("b cyc%0d", i), wc_b[i] - base, vb[i].dcyc);
        end
        chk("b frame_done cyc", fd_cyc_b - base, 75);
        chk("b rrst pulses", rr_b, 3);
        chk("b low phases", lo_b.size(), 11);
        ok = 1'b1;
        foreach (lo_b[i]) if (lo_b[i] != 3) ok = 1'b0;
        chk("b low half-period", int'(ok), 1);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
